// File: rtl/miller_symbol_decoder.sv
// Modified Miller (ISO14443A, 106 kbit/s) symbol decoder: classifies ETUs as X/Y/Z and emits bits, bytes and EOF.
// Optional odd-parity framing (9-bit characters) is enabled by defining PARITY_CHECK_EN.
module miller_symbol_decoder #(
  parameter int ETU_CLKS = 32,
  parameter int TOL      = 4
) (
  input  logic       in_clk,
  input  logic       in_PoR,
  input  logic       in_enable,
  input  logic       in_pause,
  output logic       out_bit,
  output logic       out_bit_valid,
  output logic       out_y_detected,
  output logic [7:0] out_byte,
  output logic       out_byte_valid,
  output logic       out_eof,
  output logic       out_err,
  output logic [9:0] out_bit_count
);

  localparam int PW = $clog2(ETU_CLKS);
  localparam logic [PW-1:0] LAST  = PW'(ETU_CLKS - 1);
  localparam logic [PW-1:0] TOL_P = PW'(TOL);
  localparam logic [PW-1:0] Z_LO  = PW'(ETU_CLKS - TOL);
  localparam logic [PW-1:0] X_LO  = PW'(ETU_CLKS / 2 - TOL);
  localparam logic [PW-1:0] X_HI  = PW'(ETU_CLKS / 2 + TOL);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          en_q, en_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          seen_q, seen_d;
  logic          clsx_q, clsx_d;
  logic          etuerr_q, etuerr_d;
  logic          prev_q, prev_d;
  logic [7:0]    sr_q, sr_d;
  logic [3:0]    nbits_q, nbits_d;
  logic          bit_q, bit_d;
  logic          bitv_q, bitv_d;
  logic          y_q, y_d;
  logic [7:0]    byte_q, byte_d;
  logic          bytev_q, bytev_d;
  logic          eof_q, eof_d;
  logic          err_q, err_d;
  logic [9:0]    cnt_q, cnt_d;

  logic pauseZ, pauseX, seenNow, errNow, xNow;
  logic emit, emitBit;

  // Classification of a pause at the current phase; Z wins where windows overlap.
  assign pauseZ  = (phase_q <= TOL_P) || (phase_q >= Z_LO);
  assign pauseX  = (phase_q >= X_LO) && (phase_q <= X_HI) && !pauseZ;
  assign seenNow = seen_q | in_pause;
  assign errNow  = etuerr_q | (in_pause & (seen_q | ~(pauseZ | pauseX)));
  assign xNow    = seen_q ? clsx_q : pauseX;

  always_comb begin
    state_d  = state_q;
    en_d     = in_enable;
    phase_d  = phase_q;
    seen_d   = seen_q;
    clsx_d   = clsx_q;
    etuerr_d = etuerr_q;
    prev_d   = prev_q;
    sr_d     = sr_q;
    nbits_d  = nbits_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    bitv_d   = 1'b0;
    y_d      = 1'b0;
    bytev_d  = 1'b0;
    eof_d    = 1'b0;
    emit     = 1'b0;
    emitBit  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_enable && !en_q) begin
          state_d  = S_RUN;
          phase_d  = '0;
          seen_d   = 1'b0;
          clsx_d   = 1'b0;
          etuerr_d = 1'b0;
          prev_d   = 1'b0;
          sr_d     = '0;
          nbits_d  = '0;
          err_d    = 1'b0;
          cnt_d    = '0;
        end
      end
      S_RUN: begin
        if (!in_enable) begin
          state_d = S_IDLE;
        end else begin
          phase_d = (phase_q == LAST) ? '0 : phase_q + 1'b1;
          if (phase_q == LAST) begin
            seen_d   = 1'b0;
            clsx_d   = 1'b0;
            etuerr_d = 1'b0;
            // ETU closes: decode the symbol against the previous bit.
            if (errNow || (seenNow && !xNow && prev_q)) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else if (seenNow) begin
              emit    = 1'b1;
              emitBit = xNow;
            end else begin
              y_d = 1'b1;
              if (prev_q) begin
                emit = 1'b1;
              end else begin
                eof_d   = 1'b1;
                state_d = S_DONE;
              end
            end
          end else begin
            seen_d   = seenNow;
            clsx_d   = xNow;
            etuerr_d = errNow;
          end
        end
      end
      S_DONE: begin
        if (!in_enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (emit) begin
      bitv_d = 1'b1;
      bit_d  = emitBit;
      prev_d = emitBit;
      if (cnt_q != 10'h3FF) cnt_d = cnt_q + 10'd1;
`ifdef PARITY_CHECK_EN
      // Ninth bit is odd parity over the eight data bits already shifted in.
      if (nbits_q == 4'd8) begin
        nbits_d = '0;
        if (^{sr_q, emitBit}) begin
          byte_d  = sr_q;
          bytev_d = 1'b1;
        end else begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end else begin
        sr_d    = {emitBit, sr_q[7:1]};
        nbits_d = nbits_q + 4'd1;
      end
`else
      sr_d = {emitBit, sr_q[7:1]};
      if (nbits_q == 4'd7) begin
        byte_d  = {emitBit, sr_q[7:1]};
        bytev_d = 1'b1;
        nbits_d = '0;
      end else begin
        nbits_d = nbits_q + 4'd1;
      end
`endif
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_PoR) begin
      state_q  <= S_IDLE;
      en_q     <= 1'b0;
      phase_q  <= '0;
      seen_q   <= 1'b0;
      clsx_q   <= 1'b0;
      etuerr_q <= 1'b0;
      prev_q   <= 1'b0;
      sr_q     <= '0;
      nbits_q  <= '0;
      bit_q    <= 1'b0;
      bitv_q   <= 1'b0;
      y_q      <= 1'b0;
      byte_q   <= '0;
      bytev_q  <= 1'b0;
      eof_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      phase_q  <= phase_d;
      seen_q   <= seen_d;
      clsx_q   <= clsx_d;
      etuerr_q <= etuerr_d;
      prev_q   <= prev_d;
      sr_q     <= sr_d;
      nbits_q  <= nbits_d;
      bit_q    <= bit_d;
      bitv_q   <= bitv_d;
      y_q      <= y_d;
      byte_q   <= byte_d;
      bytev_q  <= bytev_d;
      eof_q    <= eof_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_bit        = bit_q;
  assign out_bit_valid  = bitv_q;
  assign out_y_detected = y_q;
  assign out_byte       = byte_q;
  assign out_byte_valid = bytev_q;
  assign out_eof        = eof_q;
  assign out_err        = err_q;
  assign out_bit_count  = cnt_q;

endmodule
